bpsk_corr_demodulator: RTL and testbench
========================================

Name: bpsk_corr_demodulator

Overview:
- Parametrised successor to the single-word BPSK demodulator: coherent correlating receiver with signed arithmetic, symbol sync on cnt_in, and word packing.
- Multiplies incoming samples by a local sine reference, integrates over one symbol period of SAMPLE_NUMBER samples, and slices the sign to a hard bit.
- Shifts hard bits MSB-first into a DATA_WIDTH word and flags completed bits and words.
- Sits after the ADC/NCO sample path and feeds the framing/UART back end.

Parameters:
- SAMPLE_NUMBER, 256, samples per symbol (power of two, >=2)
- SAMPLE_WIDTH, 12, width of signal_in and ref_in (two's complement)
- DATA_WIDTH, 12, bits per output word (>=2)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- en  input  1  sample strobe; signal_in, ref_in and cnt_in are valid when high
- signal_in  input  SAMPLE_WIDTH  received sample, signed
- ref_in  input  SAMPLE_WIDTH  local carrier sine (bit '1' phase), signed
- cnt_in  input  $clog2(SAMPLE_NUMBER)  sample index within symbol; 0 = first sample
- bit_out  output  1  latest hard decision
- bit_valid  output  1  one-cycle pulse when bit_out updates
- q  output  DATA_WIDTH  last completed word, first received bit in MSB
- q_valid  output  1  one-cycle pulse when q updates

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high (fixed, as decided).
- Reset values: bit_out=0, bit_valid=0, q=0, q_valid=0; internal accumulator, bit counter, shift register, pipeline tags and sync flag all cleared.
- Widths:
  - product is signed 2*SAMPLE_WIDTH.
  - ACC_W = 2*SAMPLE_WIDTH + $clog2(SAMPLE_NUMBER); the accumulator cannot overflow and never wraps.
- Stage 1 (edge k, en=1):
  - prod_r <= signal_in*ref_in (signed).
  - first_r <= (cnt_in==0); last_r <= (cnt_in==SAMPLE_NUMBER-1); v_r <= 1.
  - With en=0: v_r <= 0, and prod_r, first_r, last_r hold their values.
- Stage 2 (edge k+1, v_r=1):
  - If first_r: acc <= prod_r (restart), and set sync flag.
  - Else: acc <= acc + prod_r.
  - If last_r and sync flag set (including first_r in the same cycle): sum = acc_next; decision = (sum >= 0) ? 1 : 0 (zero ties to 1).
  - On a decision: bit_out <= decision; bit_valid=1 for exactly one cycle.
- Latency: the last sample of a symbol is accepted at edge k; bit_valid is high in the cycle after edge k+1 (2-cycle latency).
- Sync:
  - Symbols accumulated before the first cnt_in==0 after reset are discarded, with no bit_valid.
  - cnt_in discontinuities need no special handling; every cnt_in==0 restarts integration.
- Packing:
  - Each decision shifts into sreg (MSB-first) and increments bit_cnt.
  - On the DATA_WIDTH-th bit: q <= completed word in the same edge as bit_out; q_valid pulses with bit_valid; bit_cnt wraps to 0.
  - q holds its value between words.
- en gaps of any length inside a symbol stall accumulation; there is no timeout.
- rst mid-symbol or mid-word: the partial symbol and partial word are dropped, sync is lost, and q is cleared to 0.

Optional Feature:
- Macro: BPSK_DIFF_DECODE_EN.
- Defined:
  - Differential decoding: the emitted bit = decision XOR prev_decision.
  - prev_decision updates on every decision and resets to 0.
  - Tolerates a 180-degree carrier phase ambiguity.
- Undefined: the emitted bit = decision; the prev_decision register is not instantiated.
- Packing, timing and valid pulses are identical in both builds.

Test Plan:
- SAMPLE_NUMBER=8, SAMPLE_WIDTH=12, DATA_WIDTH=8, ref_in = 8-point sine with amplitude 1000, en continuous, symbols signal=+ref/-ref for pattern 0xA5 -> 8 bit_valid pulses with bits 1,0,1,0,0,1,0,1; q=0xA5 and q_valid single pulse 2 cycles after the 64th sample.
- Same stream with en randomly low 50% of cycles -> identical q=0xA5; pulses are delayed but each is one cycle wide.
- Start stream at cnt_in=3 -> no bit_valid until the first full symbol; the first word starts with the bit of the symbol beginning at cnt_in=0.
- signal_in=0 for one symbol -> bit_out=1 (zero tie); signal_in=-2048 with ref_in=-2048 for all 8 samples -> bit_out=1, accumulator holds +33554432 with no overflow.
- rst asserted after 5 bits of a word -> q=0 next cycle; the next 8 full symbols 0x3C produce q=0x3C.
- BPSK_DIFF_DECODE_EN defined, symbols 1,1,0,0,1,0,1,1 -> emitted bits 1,0,1,0,1,1,1,0, q=0xAE.

Source files
------------

// File: rtl/bpsk_corr_demodulator.sv
// Coherent BPSK correlating demodulator: multiply, integrate per symbol, slice, pack MSB-first.
// Optional BPSK_DIFF_DECODE_EN: emit decision XOR previous decision (180-degree ambiguity).
module bpsk_corr_demodulator #(
    parameter int SAMPLE_NUMBER = 256,
    parameter int SAMPLE_WIDTH  = 12,
    parameter int DATA_WIDTH    = 12,
    localparam int CW = $clog2(SAMPLE_NUMBER)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic signed [SAMPLE_WIDTH-1:0] signal_in,
    input  logic signed [SAMPLE_WIDTH-1:0] ref_in,
    input  logic        [CW-1:0]           cnt_in,
    output logic                           bit_out,
    output logic                           bit_valid,
    output logic        [DATA_WIDTH-1:0]   q,
    output logic                           q_valid
);

    localparam int PW    = 2 * SAMPLE_WIDTH;
    localparam int ACC_W = PW + CW;
    localparam int BW    = $clog2(DATA_WIDTH);

    logic signed [PW-1:0]    prod_q, prod_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;
    logic                    v_q, v_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    sync_q, sync_d;
    logic                    bit_q, bit_d;
    logic                    bv_q, bv_d;
    logic [DATA_WIDTH-1:0]   sreg_q, sreg_d;
    logic [BW-1:0]           bcnt_q, bcnt_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic                    qv_q, qv_d;
`ifdef BPSK_DIFF_DECODE_EN
    logic                    prev_q, prev_d;
`endif

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic                    sync_next;
    logic                    fire;
    logic                    decision;
    logic                    emit;
    logic [DATA_WIDTH-1:0]   sreg_next;

    always_comb begin
        prod_d  = prod_q;
        first_d = first_q;
        last_d  = last_q;
        v_d     = en;
        if (en) begin
            prod_d  = signal_in * ref_in;
            first_d = (cnt_in == '0);
            last_d  = (cnt_in == CW'(SAMPLE_NUMBER - 1));
        end
    end

    // Sync flag is folded in combinationally so a first+last symbol still decides.
    always_comb begin
        prod_ext  = prod_q;
        acc_next  = first_q ? prod_ext : acc_q + prod_ext;
        sync_next = sync_q | first_q;
        fire      = v_q & last_q & sync_next;
        decision  = ~acc_next[ACC_W-1];
`ifdef BPSK_DIFF_DECODE_EN
        emit      = decision ^ prev_q;
`else
        emit      = decision;
`endif
        sreg_next = {sreg_q[DATA_WIDTH-2:0], emit};
    end

    always_comb begin
        acc_d  = acc_q;
        sync_d = sync_q;
        bit_d  = bit_q;
        bv_d   = 1'b0;
        sreg_d = sreg_q;
        bcnt_d = bcnt_q;
        word_d = word_q;
        qv_d   = 1'b0;
`ifdef BPSK_DIFF_DECODE_EN
        prev_d = prev_q;
`endif
        if (v_q) begin
            acc_d  = acc_next;
            sync_d = sync_next;
        end
        if (fire) begin
            bit_d  = emit;
            bv_d   = 1'b1;
            sreg_d = sreg_next;
`ifdef BPSK_DIFF_DECODE_EN
            prev_d = decision;
`endif
            if (bcnt_q == BW'(DATA_WIDTH - 1)) begin
                word_d = sreg_next;
                qv_d   = 1'b1;
                bcnt_d = '0;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            v_q     <= 1'b0;
            acc_q   <= '0;
            sync_q  <= 1'b0;
            bit_q   <= 1'b0;
            bv_q    <= 1'b0;
            sreg_q  <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            qv_q    <= 1'b0;
`ifdef BPSK_DIFF_DECODE_EN
            prev_q  <= 1'b0;
`endif
        end else begin
            prod_q  <= prod_d;
            first_q <= first_d;
            last_q  <= last_d;
            v_q     <= v_d;
            acc_q   <= acc_d;
            sync_q  <= sync_d;
            bit_q   <= bit_d;
            bv_q    <= bv_d;
            sreg_q  <= sreg_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            qv_q    <= qv_d;
`ifdef BPSK_DIFF_DECODE_EN
            prev_q  <= prev_d;
`endif
        end
    end

    assign bit_out   = bit_q;
    assign bit_valid = bv_q;
    assign q         = word_q;
    assign q_valid   = qv_q;

endmodule

// File: tb/tb_bpsk_corr_demodulator.sv
// Bench for bpsk_corr_demodulator: table rows, corner sequences and random words
// checked against a symbol-level model of the correlating receiver.
module tb_bpsk_corr_demodulator;

    localparam int N  = 8;
    localparam int SW = 12;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic signed [SW-1:0] sig = '0;
    logic signed [SW-1:0] rf = '0;
    logic [2:0]           cnt = '0;
    logic                 bit_out, bit_valid, q_valid;
    logic [DW-1:0]        q;

    bpsk_corr_demodulator #(
        .SAMPLE_NUMBER(N),
        .SAMPLE_WIDTH(SW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .signal_in(sig),
        .ref_in(rf),
        .cnt_in(cnt),
        .bit_out(bit_out),
        .bit_valid(bit_valid),
        .q(q),
        .q_valid(q_valid)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit mon_on = 1'b0;
    int sine [N] = '{0, 707, 1000, 707, 0, -707, -1000, -707};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Symbol-level reference: integrate accepted samples, decide on the last one.
    typedef struct {
        int cyc;
        bit b;
        bit word;
        int w;
    } ev_t;
    ev_t expq[$];

    int       acc_m;
    bit       sync_m;
    int       nb_m;
    bit [7:0] w_m;
    bit       prev_m;

    task automatic model_reset();
        acc_m = 0; sync_m = 0; nb_m = 0; w_m = '0; prev_m = 0;
        expq.delete();
    endtask

    task automatic model_sample(int s, int r, int c, int edge_n);
        ev_t e;
        bit d, b;
        int p;
        p = s * r;
        if (c == 0) begin
            acc_m = p;
            sync_m = 1;
        end else begin
            acc_m += p;
        end
        if (c == N - 1 && sync_m) begin
            d = (acc_m >= 0);
`ifdef BPSK_DIFF_DECODE_EN
            b = d ^ prev_m;
            prev_m = d;
`else
            b = d;
`endif
            w_m = {w_m[6:0], b};
            nb_m++;
            e.cyc = edge_n + 1;
            e.b = b;
            e.word = (nb_m == DW);
            e.w = w_m;
            if (nb_m == DW) nb_m = 0;
            expq.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_on) begin
            if (bit_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious bit_valid", bit_valid, 0);
                end else begin
                    e = expq.pop_front();
                    chk("bit_valid cycle", cyc, e.cyc);
                    chk("bit_out", bit_out, e.b);
                    chk("q_valid with bit", q_valid, e.word);
                    if (e.word) chk("q word", q, e.w);
                end
            end else begin
                chk("q_valid without bit_valid", q_valid, 0);
                if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                    chk("bit_valid expected", bit_valid, 1);
                    void'(expq.pop_front());
                end
            end
        end
    end

    task automatic step(bit e, int s, int r, int c);
        en = e;
        sig = SW'(s);
        rf = SW'(r);
        cnt = 3'(c);
        @(posedge clk);
        #1;
        if (e) model_sample(int'(sig), int'(rf), c, cyc);
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, 0, 0);
    endtask

    task automatic send_sym(bit b, int en_pct, int start, int noise);
        int s;
        for (int c = start; c < N; c++) begin
            while (int'($urandom_range(99)) >= en_pct)
                step(0, int'($urandom), int'($urandom), int'($urandom_range(7)));
            s = b ? sine[c] : -sine[c];
            if (noise > 0) s += int'($urandom_range(2 * noise)) - noise;
            step(1, s, sine[c], c);
        end
    endtask

    task automatic send_word(bit [7:0] p, int en_pct, int noise);
        for (int i = 7; i >= 0; i--) send_sym(p[i], en_pct, 0, noise);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        en = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        chk("reset q", q, 0);
        chk("reset bit_out", bit_out, 0);
        chk("reset bit_valid", bit_valid, 0);
        chk("reset q_valid", q_valid, 0);
        rst = 1'b0;
    endtask

    task automatic do_reset();
        idle(3);
        pulse_reset();
    endtask

    typedef struct {
        bit [7:0] pat;
        int       en_pct;
        int       start;
        bit [7:0] exp_q;
        bit [7:0] exp_qd;
    } row_t;
    row_t rows [5];

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [7:0] exp;
        rows[0] = '{8'hA5, 100, 0, 8'hA5, 8'hF7};
        rows[1] = '{8'hA5, 50, 0, 8'hA5, 8'hF7};
        rows[2] = '{8'h3C, 100, 3, 8'h3C, 8'h22};
        rows[3] = '{8'hCB, 70, 0, 8'hCB, 8'hAE};
        rows[4] = '{8'hFF, 100, 0, 8'hFF, 8'h80};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();
        mon_on = 1'b1;

        foreach (rows[i]) begin
            do_reset();
            if (rows[i].start != 0) send_sym(1'b1, rows[i].en_pct, rows[i].start, 0);
            send_word(rows[i].pat, rows[i].en_pct, 0);
            idle(4);
`ifdef BPSK_DIFF_DECODE_EN
            exp = rows[i].exp_qd;
`else
            exp = rows[i].exp_q;
`endif
            chk($sformatf("row%0d q", i), q, exp);
        end

        do_reset();
        send_sym(1'b0, 100, 0, 0);
        idle(3);
        chk("bit before tie", bit_out, 0);
        for (int c = 0; c < N; c++) step(1, 0, sine[c], c);
        idle(3);
        chk("zero tie bit", bit_out, 1);
        send_sym(1'b0, 100, 0, 0);
        for (int c = 0; c < N; c++) step(1, -2048, -2048, c);
        idle(3);
        chk("extreme bit", bit_out, 1);
        chk("extreme acc", 32'(int'(dut.acc_q)), 33554432);

        do_reset();
        send_word(8'h5A, 100, 0);
        idle(3);
        chk("pre-reset q", q, 8'h5A);
        for (int i = 0; i < 5; i++) send_sym(1'b1, 100, 0, 0);
        idle(3);
        pulse_reset();
        send_word(8'h3C, 100, 0);
        idle(4);
`ifdef BPSK_DIFF_DECODE_EN
        chk("after reset q", q, 8'h22);
`else
        chk("after reset q", q, 8'h3C);
`endif

        do_reset();
        for (int w = 0; w < 6; w++) begin
            if (w == 3)
                for (int c = 0; c < 5; c++) step(1, int'($urandom), sine[c], c);
            send_word(8'($urandom), 60, 300);
        end
        idle(5);
        chk("queue drained", expq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
